// File: rtl/air_hockey_pkg.sv
// ----------------------------------------------------------------------------
// air_hockey_pkg
// Shared constants and helpers for the puck position engine.
//   - Rink geometry (SCREEN_W/H), puck radius, goal mouth rows.
//   - Velocity format: signed VEL_W-bit, magnitude MAG_W bits, capped at VMAX.
//   - Update FSM state encodings (ST_*), shared by the engine and its
//     debug output.
//   - Velocity helpers: magnitude, saturating increment, floored decrement,
//     and rebuild-from-magnitude-and-sign.
// ----------------------------------------------------------------------------
package air_hockey_pkg;

    localparam int SCREEN_W          = 1024;
    localparam int SCREEN_H          = 768;
    localparam int PUCK_R            = 15;
    localparam int GOAL_Y0           = 284;
    localparam int GOAL_Y1           = 484;
    localparam int VMAX              = 15;
    localparam int DEF_SERVE_FRAMES  = 60;

    localparam int POS_W = 12;   // on-screen coordinate width
    localparam int CALC_W = 14;  // signed working width for next position
    localparam int VEL_W = 5;    // signed velocity width
    localparam int MAG_W = 4;    // velocity magnitude width

    // Update FSM encoding, one state per clock.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_MOVE   = 3'd1;
    localparam state_t ST_WALL   = 3'd2;
    localparam state_t ST_HIT1   = 3'd3;
    localparam state_t ST_HIT2   = 3'd4;
    localparam state_t ST_GOAL   = 3'd5;
    localparam state_t ST_COMMIT = 3'd6;

    // |v|; velocities never reach -16, so the magnitude fits MAG_W bits.
    function automatic logic [MAG_W-1:0] vel_mag(input logic signed [VEL_W-1:0] v);
        return v[VEL_W-1] ? MAG_W'(-v) : v[MAG_W-1:0];
    endfunction

    function automatic logic [MAG_W-1:0] mag_inc(input logic [MAG_W-1:0] m);
        return (m >= MAG_W'(VMAX)) ? MAG_W'(VMAX) : m + MAG_W'(1);
    endfunction

    // Speed never drops below 1 so the puck can not stall.
    function automatic logic [MAG_W-1:0] mag_dec(input logic [MAG_W-1:0] m);
        return (m > MAG_W'(1)) ? m - MAG_W'(1) : MAG_W'(1);
    endfunction

    function automatic logic signed [VEL_W-1:0] vel_from(input logic [MAG_W-1:0] m,
                                                         input logic neg);
        logic signed [VEL_W-1:0] p;
        p = {1'b0, m};
        return neg ? -p : p;
    endfunction

endpackage

// File: rtl/circle_hit.sv
// ----------------------------------------------------------------------------
// circle_hit
// Combinational puck-vs-mallet overlap test.
//   i_cx, i_cy  : puck centre, signed CALC_W bits (may sit off-screen in a goal)
//   i_px, i_py  : mallet centre, unsigned POS_W bits
//   i_pr        : mallet radius
//   o_hit       : dx*dx + dy*dy <= (PUCK_R + i_pr)^2
//   o_dx_neg    : dx < 0 (puck is left of the mallet centre)
//   o_dy_neg    : dy < 0 (puck is above the mallet centre)
// dx/dy are evaluated as signed 13-bit values; an offset that does not fit
// 13 bits is far beyond any mallet reach and is reported as no hit.
// ----------------------------------------------------------------------------
module circle_hit
    import air_hockey_pkg::*;
(
    input  logic signed [CALC_W-1:0] i_cx,
    input  logic signed [CALC_W-1:0] i_cy,
    input  logic        [POS_W-1:0]  i_px,
    input  logic        [POS_W-1:0]  i_py,
    input  logic        [7:0]        i_pr,
    output logic                     o_hit,
    output logic                     o_dx_neg,
    output logic                     o_dy_neg
);

    logic signed [CALC_W-1:0] w_dx_full;
    logic signed [CALC_W-1:0] w_dy_full;
    logic signed [12:0]       w_dx;
    logic signed [12:0]       w_dy;
    logic [12:0]              w_adx;
    logic [12:0]              w_ady;
    logic                     w_far;
    logic [25:0]              w_d2;
    logic [8:0]               w_rsum;
    logic [25:0]              w_r2;

    assign w_dx_full = i_cx - $signed({2'b00, i_px});
    assign w_dy_full = i_cy - $signed({2'b00, i_py});
    assign w_dx      = w_dx_full[12:0];
    assign w_dy      = w_dy_full[12:0];

    // Top two bits disagreeing means the offset overflowed 13 bits.
    assign w_far = (w_dx_full[13] != w_dx_full[12]) || (w_dy_full[13] != w_dy_full[12]);

    assign w_adx = w_dx[12] ? 13'(-w_dx) : 13'(w_dx);
    assign w_ady = w_dy[12] ? 13'(-w_dy) : 13'(w_dy);

    assign w_d2   = ({13'd0, w_adx} * {13'd0, w_adx}) + ({13'd0, w_ady} * {13'd0, w_ady});
    assign w_rsum = 9'(PUCK_R) + {1'b0, i_pr};
    assign w_r2   = {17'd0, w_rsum} * {17'd0, w_rsum};

    assign o_hit    = !w_far && (w_d2 <= w_r2);
    assign o_dx_neg = w_dx[12];
    assign o_dy_neg = w_dy[12];

endmodule

// File: rtl/puck_ctl.sv
// ----------------------------------------------------------------------------
// puck_ctl
// Per-frame puck position engine. On each vblank rising edge it advances the
// puck by its velocity, bounces off the rink walls (except across the goal
// mouth), deflects off the two mallets, detects goals and publishes the new
// centre to the downstream draw stage.
//
// Ports
//   clk_in            pixel clock
//   rst               synchronous active-high reset
//   vblnk_in          vertical blank; its rising edge is the frame tick
//   p1_x/p1_y/p1_r    left mallet centre and radius
//   p2_x/p2_y/p2_r    right mallet centre and radius
//   xpos_out/ypos_out puck centre, only changes at the end of an update burst
//   goal_l/goal_r     one-cycle pulse when the puck enters the left/right goal
//   busy              update FSM is not IDLE
//   dbg_state         current FSM state (ST_* encoding)
//   dbg_vx/dbg_vy     current signed velocity
//
// Handshake: there is none; a tick is accepted only in IDLE, a tick seen in
// any other state is dropped, and outputs are held between bursts.
//
// Configuration macro: PUCK_FRICTION_EN. When defined, every 16th moving
// frame without a mallet hit reduces |vx| and |vy| by 1 (floor 1).
// ----------------------------------------------------------------------------
module puck_ctl
    import air_hockey_pkg::*;
#(
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int INIT_X       = SCREEN_W / 2,
    parameter int INIT_Y       = SCREEN_H / 2,
    parameter int INIT_VX      = 2,
    parameter int INIT_VY      = 1
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    vblnk_in,
    input  logic [11:0]             p1_x,
    input  logic [11:0]             p1_y,
    input  logic [7:0]              p1_r,
    input  logic [11:0]             p2_x,
    input  logic [11:0]             p2_y,
    input  logic [7:0]              p2_r,
    output logic [11:0]             xpos_out,
    output logic [11:0]             ypos_out,
    output logic                    goal_l,
    output logic                    goal_r,
    output logic                    busy,
    output logic [2:0]              dbg_state,
    output logic signed [VEL_W-1:0] dbg_vx,
    output logic signed [VEL_W-1:0] dbg_vy
);

    localparam logic signed [CALC_W-1:0] LIM_LO   = CALC_W'(PUCK_R);
    localparam logic signed [CALC_W-1:0] LIM_HI_X = CALC_W'(SCREEN_W - 1 - PUCK_R);
    localparam logic signed [CALC_W-1:0] LIM_HI_Y = CALC_W'(SCREEN_H - 1 - PUCK_R);
    localparam logic signed [CALC_W-1:0] MOUTH_Y0 = CALC_W'(GOAL_Y0);
    localparam logic signed [CALC_W-1:0] MOUTH_Y1 = CALC_W'(GOAL_Y1);
    localparam logic signed [CALC_W-1:0] X_EDGE   = CALC_W'(SCREEN_W - 1);
    localparam logic signed [CALC_W-1:0] CTR_X    = CALC_W'(SCREEN_W / 2);
    localparam logic signed [CALC_W-1:0] CTR_Y    = CALC_W'(SCREEN_H / 2);
    localparam logic [7:0]               SERVE_LD = 8'(SERVE_FRAMES);

    state_t                   r_state;
    logic                     r_vq;
    logic                     r_vqq;
    logic [POS_W-1:0]         r_x;
    logic [POS_W-1:0]         r_y;
    logic signed [CALC_W-1:0] r_nx;
    logic signed [CALC_W-1:0] r_ny;
    logic signed [VEL_W-1:0]  r_vx;
    logic signed [VEL_W-1:0]  r_vy;
    logic [7:0]               r_serve;
    logic                     r_hit1;
    logic                     r_hit2;
    logic                     r_goal_l;
    logic                     r_goal_r;
`ifdef PUCK_FRICTION_EN
    logic [3:0]               r_fric;
`endif

    logic                     w_tick;
    logic                     w_sel_p2;
    logic [POS_W-1:0]         w_px;
    logic [POS_W-1:0]         w_py;
    logic [7:0]               w_pr;
    logic                     w_hit;
    logic                     w_dx_neg;
    logic                     w_dy_neg;
    logic                     w_in_mouth;
    logic signed [VEL_W-1:0]  w_vx_hit;
    logic signed [VEL_W-1:0]  w_vy_hit;

    // Frame tick: one-cycle pulse a cycle after vblnk_in rises.
    assign w_tick = r_vq && !r_vqq;

    // A single overlap tester serves both mallets; HIT2 selects mallet 2.
    assign w_sel_p2 = (r_state == ST_HIT2);
    assign w_px     = w_sel_p2 ? p2_x : p1_x;
    assign w_py     = w_sel_p2 ? p2_y : p1_y;
    assign w_pr     = w_sel_p2 ? p2_r : p1_r;

    circle_hit u_hit (
        .i_cx     (r_nx),
        .i_cy     (r_ny),
        .i_px     (w_px),
        .i_py     (w_py),
        .i_pr     (w_pr),
        .o_hit    (w_hit),
        .o_dx_neg (w_dx_neg),
        .o_dy_neg (w_dy_neg)
    );

    // On a hit the puck is pushed away from the mallet centre and sped up.
    assign w_vx_hit = vel_from(mag_inc(vel_mag(r_vx)), w_dx_neg);
    assign w_vy_hit = vel_from(mag_inc(vel_mag(r_vy)), w_dy_neg);

    assign w_in_mouth = (r_ny >= MOUTH_Y0) && (r_ny <= MOUTH_Y1);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            // Held high so a vblank already asserted at reset release is
            // not mistaken for a fresh frame edge.
            r_vq     <= 1'b1;
            r_vqq    <= 1'b1;
            r_x      <= POS_W'(INIT_X);
            r_y      <= POS_W'(INIT_Y);
            r_nx     <= CALC_W'(INIT_X);
            r_ny     <= CALC_W'(INIT_Y);
            r_vx     <= VEL_W'(INIT_VX);
            r_vy     <= VEL_W'(INIT_VY);
            r_serve  <= SERVE_LD;
            r_hit1   <= 1'b0;
            r_hit2   <= 1'b0;
            r_goal_l <= 1'b0;
            r_goal_r <= 1'b0;
`ifdef PUCK_FRICTION_EN
            r_fric   <= 4'd0;
`endif
        end else begin
            r_vq     <= vblnk_in;
            r_vqq    <= r_vq;
            r_goal_l <= 1'b0;
            r_goal_r <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        if (r_serve != 8'd0) begin
                            r_serve <= r_serve - 8'd1;
                        end else begin
                            r_state <= ST_MOVE;
                        end
                    end
                end

                ST_MOVE: begin
                    r_nx    <= $signed({2'b00, r_x}) + $signed({{(CALC_W-VEL_W){r_vx[VEL_W-1]}}, r_vx});
                    r_ny    <= $signed({2'b00, r_y}) + $signed({{(CALC_W-VEL_W){r_vy[VEL_W-1]}}, r_vy});
                    r_hit1  <= 1'b0;
                    r_hit2  <= 1'b0;
                    r_state <= ST_WALL;
                end

                ST_WALL: begin
                    if (r_ny < LIM_LO) begin
                        r_ny <= LIM_LO;
                        r_vy <= -r_vy;
                    end else if (r_ny > LIM_HI_Y) begin
                        r_ny <= LIM_HI_Y;
                        r_vy <= -r_vy;
                    end
                    // Across the goal mouth the side walls are open.
                    if (!w_in_mouth) begin
                        if (r_nx < LIM_LO) begin
                            r_nx <= LIM_LO;
                            r_vx <= -r_vx;
                        end else if (r_nx > LIM_HI_X) begin
                            r_nx <= LIM_HI_X;
                            r_vx <= -r_vx;
                        end
                    end
                    r_state <= ST_HIT1;
                end

                ST_HIT1: begin
                    if (w_hit) begin
                        r_vx   <= w_vx_hit;
                        r_vy   <= w_vy_hit;
                        r_hit1 <= 1'b1;
                    end
                    r_state <= ST_HIT2;
                end

                ST_HIT2: begin
                    // Mallet 1 has priority when both overlap the puck.
                    if (!r_hit1 && w_hit) begin
                        r_vx   <= w_vx_hit;
                        r_vy   <= w_vy_hit;
                        r_hit2 <= 1'b1;
                    end
                    r_state <= ST_GOAL;
                end

                ST_GOAL: begin
                    if (r_nx[CALC_W-1]) begin
                        // Left goal: re-serve moving toward the conceding side.
                        r_goal_l <= 1'b1;
                        r_nx     <= CTR_X;
                        r_ny     <= CTR_Y;
                        r_vx     <= -VEL_W'(2);
                        r_vy     <= VEL_W'(1);
                        r_serve  <= SERVE_LD;
                    end else if (r_nx > X_EDGE) begin
                        r_goal_r <= 1'b1;
                        r_nx     <= CTR_X;
                        r_ny     <= CTR_Y;
                        r_vx     <= VEL_W'(2);
                        r_vy     <= VEL_W'(1);
                        r_serve  <= SERVE_LD;
                    end else begin
`ifdef PUCK_FRICTION_EN
                        r_fric <= r_fric + 4'd1;
                        if ((r_fric == 4'd15) && !r_hit1 && !r_hit2) begin
                            r_vx <= vel_from(mag_dec(vel_mag(r_vx)), r_vx[VEL_W-1]);
                            r_vy <= vel_from(mag_dec(vel_mag(r_vy)), r_vy[VEL_W-1]);
                        end
`endif
                    end
                    r_state <= ST_COMMIT;
                end

                ST_COMMIT: begin
                    // WALL/GOAL guarantee nx/ny are on-screen here.
                    r_x     <= r_nx[POS_W-1:0];
                    r_y     <= r_ny[POS_W-1:0];
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign xpos_out  = r_x;
    assign ypos_out  = r_y;
    assign goal_l    = r_goal_l;
    assign goal_r    = r_goal_r;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
    assign dbg_vx    = r_vx;
    assign dbg_vy    = r_vy;

endmodule

// File: tb/tb_puck_ctl.sv
// ----------------------------------------------------------------------------
// tb_puck_ctl
// Directed bench for puck_ctl. Several instances share clock, reset, vblank
// and mallet inputs but start from different puck states, so each directed
// scenario can be observed from its first frame:
//   0 default reset state (serve delay 60)
//   1 (512,16)   v=(+2,-3)  top wall
//   2 (20,100)   v=(-8,+1)  left wall outside goal mouth
//   3 (5,384)    v=(-8,+1)  left goal
//   4 (512,384)  v=(+15,+1) saturation / mallet priority / reset mid-burst
//   5 (512,384)  v=(+5,+1)  plain hit increment / friction
//   6 (1018,384) v=(+8,+1)  right goal
// ----------------------------------------------------------------------------
module tb_puck_ctl;

    localparam int N = 7;
    localparam int IX [N] = '{512, 512,  20,   5, 512, 512, 1018};
    localparam int IY [N] = '{384,  16, 100, 384, 384, 384,  384};
    localparam int IVX[N] = '{  2,   2,  -8,  -8,  15,   5,    8};
    localparam int IVY[N] = '{  1,  -3,   1,   1,   1,   1,    1};
    localparam int ISV[N] = '{ 60,   0,   0,   0,   0,   0,    0};

    localparam logic [2:0] EXP_IDLE = 3'd0;
    localparam logic [2:0] EXP_HIT1 = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst      = 1'b1;
    logic        vblnk_in = 1'b0;
    logic [11:0] p1_x = 12'd100, p1_y = 12'd700, p2_x = 12'd900, p2_y = 12'd700;
    logic [7:0]  p1_r = 8'd10,   p2_r = 8'd10;

    logic [11:0]       xo  [N];
    logic [11:0]       yo  [N];
    logic              gl  [N];
    logic              gr  [N];
    logic              bz  [N];
    logic [2:0]        st  [N];
    logic signed [4:0] vxo [N];
    logic signed [4:0] vyo [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        puck_ctl #(
            .SERVE_FRAMES (ISV[g]),
            .INIT_X       (IX[g]),
            .INIT_Y       (IY[g]),
            .INIT_VX      (IVX[g]),
            .INIT_VY      (IVY[g])
        ) u_dut (
            .clk_in    (clk_in),
            .rst       (rst),
            .vblnk_in  (vblnk_in),
            .p1_x      (p1_x),
            .p1_y      (p1_y),
            .p1_r      (p1_r),
            .p2_x      (p2_x),
            .p2_y      (p2_y),
            .p2_r      (p2_r),
            .xpos_out  (xo[g]),
            .ypos_out  (yo[g]),
            .goal_l    (gl[g]),
            .goal_r    (gr[g]),
            .busy      (bz[g]),
            .dbg_state (st[g]),
            .dbg_vx    (vxo[g]),
            .dbg_vy    (vyo[g])
        );
    end

    // ---------------- goal pulse counters ----------------
    int   gl_cnt [N];
    int   gr_cnt [N];
    logic clr_cnt = 1'b1;

    always @(negedge clk_in) begin
        for (int g = 0; g < N; g++) begin
            if (clr_cnt) begin
                gl_cnt[g] <= 0;
                gr_cnt[g] <= 0;
            end else begin
                if (gl[g]) gl_cnt[g] <= gl_cnt[g] + 1;
                if (gr[g]) gr_cnt[g] <= gr_cnt[g] + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        @(negedge clk_in);
        clr_cnt = 1'b1;
        repeat (2) @(negedge clk_in);
        clr_cnt = 1'b0;
    endtask

    task automatic set_mallets(input int x1, input int y1, input int r1,
                               input int x2, input int y2, input int r2);
        @(negedge clk_in);
        p1_x = 12'(x1); p1_y = 12'(y1); p1_r = 8'(r1);
        p2_x = 12'(x2); p2_y = 12'(y2); p2_r = 8'(r2);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst      = 1'b1;
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    // One frame: vblank high long enough for the whole update burst.
    task automatic do_tick();
        @(negedge clk_in);
        vblnk_in = 1'b1;
        repeat (12) @(negedge clk_in);
        vblnk_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic far_mallets();
        set_mallets(100, 700, 10, 900, 700, 10);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;

        // Reset state.
        far_mallets();
        do_reset();
        clear_counts();
        check("rst_x",     int'(xo[0]), 512);
        check("rst_y",     int'(yo[0]), 384);
        check("rst_vx",    int'(vxo[0]), 2);
        check("rst_vy",    int'(vyo[0]), 1);
        check("rst_busy",  int'(bz[0]), 0);
        check("rst_state", int'(st[0]), int'(EXP_IDLE));
        check("rst_goal",  int'(gl[0]) + int'(gr[0]), 0);

        // First frame on the serve-free instances.
        do_tick();
        check("top_wall_x",  int'(xo[1]), 514);
        check("top_wall_y",  int'(yo[1]), 15);
        check("top_wall_vy", int'(vyo[1]), 3);
        check("side_wall_x",  int'(xo[2]), 15);
        check("side_wall_y",  int'(yo[2]), 101);
        check("side_wall_vx", int'(vxo[2]), 8);
        check("goal_l_pulse", gl_cnt[3], 1);
        check("goal_l_nor",   gr_cnt[3], 0);
        check("goal_l_x",     int'(xo[3]), 512);
        check("goal_l_y",     int'(yo[3]), 384);
        check("goal_l_vx",    int'(vxo[3]), -2);
        check("goal_l_vy",    int'(vyo[3]), 1);
        check("goal_r_pulse", gr_cnt[6], 1);
        check("goal_r_nol",   gl_cnt[6], 0);
        check("goal_r_x",     int'(xo[6]), 512);
        check("goal_r_vx",    int'(vxo[6]), 2);

        // Serve delay: 60 ticks frozen, 61st moves.
        do_ticks(59);
        check("serve_hold_x", int'(xo[0]), 512);
        check("serve_hold_y", int'(yo[0]), 384);
        do_tick();
        check("serve_move_x", int'(xo[0]), 514);
        check("serve_move_y", int'(yo[0]), 385);
        check("serve_busy",   int'(bz[0]), 0);

        // Mallet 1 deflection on the default instance.
        far_mallets();
        do_reset();
        do_ticks(60);
        set_mallets(540, 384, 20, 900, 700, 10);
        do_tick();
        check("hit1_x",  int'(xo[0]), 514);
        check("hit1_y",  int'(yo[0]), 385);
        check("hit1_vx", int'(vxo[0]), -3);
        check("hit1_vy", int'(vyo[0]), 2);
        do_tick();
        check("hit1_next_x",  int'(xo[0]), 511);
        check("hit1_next_y",  int'(yo[0]), 387);
        check("hit1_next_vx", int'(vxo[0]), -4);

        // Saturation at VMAX and repeated hits.
        set_mallets(540, 384, 20, 900, 700, 10);
        do_reset();
        do_tick();
        check("sat_x",   int'(xo[4]), 527);
        check("sat_vx",  int'(vxo[4]), -15);
        check("sat_vy",  int'(vyo[4]), 2);
        check("inc_vx",  int'(vxo[5]), -6);
        do_tick();
        check("sat2_x",  int'(xo[4]), 512);
        check("sat2_vx", int'(vxo[4]), -15);
        check("sat2_vy", int'(vyo[4]), 3);

        // Both mallets overlapping: mallet 1 wins.
        set_mallets(540, 384, 20, 500, 384, 20);
        do_reset();
        do_tick();
        check("both_e_vx", int'(vxo[4]), -15);
        check("both_f_vx", int'(vxo[5]), -6);
        check("both_f_vy", int'(vyo[5]), 2);

        // Mallet 2 alone.
        set_mallets(100, 700, 10, 500, 384, 20);
        do_reset();
        do_tick();
        check("hit2_f_vx", int'(vxo[5]), 6);
        check("hit2_f_vy", int'(vyo[5]), 2);
        check("hit2_e_vx", int'(vxo[4]), 15);

        // Reset while the burst is in HIT1.
        far_mallets();
        do_reset();
        clear_counts();
        @(negedge clk_in);
        vblnk_in = 1'b1;
        waited = 0;
        while ((st[4] != EXP_HIT1) && (waited < 20)) begin
            @(negedge clk_in);
            waited++;
        end
        check("mid_reach_hit1", int'(st[4]), int'(EXP_HIT1));
        check("mid_busy_hi",    int'(bz[4]), 1);
        rst      = 1'b1;
        vblnk_in = 1'b0;
        @(negedge clk_in);
        rst = 1'b0;
        check("mid_state", int'(st[4]), int'(EXP_IDLE));
        check("mid_busy",  int'(bz[4]), 0);
        check("mid_x",     int'(xo[4]), 512);
        check("mid_vx",    int'(vxo[4]), 15);
        repeat (10) @(negedge clk_in);
        check("mid_no_goal", gl_cnt[3], 0);
        check("mid_d_x",     int'(xo[3]), 5);

        // 32 quiet frames at |vx|=5.
        far_mallets();
        do_reset();
        do_ticks(32);
`ifdef PUCK_FRICTION_EN
        check("fric_vx", int'(vxo[5]), 3);
        check("fric_x",  int'(xo[5]), 656);
`else
        check("nofric_vx", int'(vxo[5]), 5);
        check("nofric_x",  int'(xo[5]), 672);
`endif
        check("fric_vy", int'(vyo[5]), 1);
        check("fric_y",  int'(yo[5]), 416);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
